// File: rtl/regfile_sb_if.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_sb_if
//  Description : Port bundle for regfile_sb: two write ports, two read ports
//                with busy status, issue strobe and pending count.
//  Revision    : 1.0 - initial release
// ============================================================================
interface regfile_sb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              we0;
    logic [ADDR_W-1:0] wa0;
    logic [DATA_W-1:0] wd0;
    logic              we1;
    logic [ADDR_W-1:0] wa1;
    logic [DATA_W-1:0] wd1;
    logic [ADDR_W-1:0] ra1;
    logic [ADDR_W-1:0] ra2;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic              iss_en;
    logic [ADDR_W-1:0] iss_addr;
    logic              busy1;
    logic              busy2;
    logic [ADDR_W:0]   pend_cnt;

    // Requester side: drives writes, reads and issues; observes results.
    modport master (
        output we0, wa0, wd0, we1, wa1, wd1, ra1, ra2, iss_en, iss_addr,
        input  rd1, rd2, busy1, busy2, pend_cnt
    );

    // Register file side.
    modport slave (
        input  we0, wa0, wd0, we1, wa1, wd1, ra1, ra2, iss_en, iss_addr,
        output rd1, rd2, busy1, busy2, pend_cnt
    );
endinterface
`default_nettype wire

// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_sb
//  Description : Two-write / two-read register file with write-through read
//                bypass and a per-register pending scoreboard. Port 1 has
//                priority on address collisions; an issue to the register
//                being written in the same cycle keeps it pending.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  wire logic     clk,
    input  wire logic     reset,
    regfile_sb_if.slave   bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CNT_W = ADDR_W + 1;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]  pend_q;
    logic [DEPTH-1:0]  pend_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;

    logic                        zr;
    logic                        wv0;
    logic                        wv1;
    logic                        iv;
    logic [1:0][ADDR_W-1:0]      ra;
    logic [1:0][DATA_W-1:0]      rd;
    logic [1:0]                  busy;

    // A write or issue targeting the hardwired zero register has no effect.
    assign zr  = (ZERO_REG != 0);
    assign wv0 = bus.we0    && !(zr && (bus.wa0 == '0));
    assign wv1 = bus.we1    && !(zr && (bus.wa1 == '0));
    assign iv  = bus.iss_en && !(zr && (bus.iss_addr == '0));

    assign ra = {bus.ra2, bus.ra1};

    // Read ports: zero register, then port 1 bypass, then port 0 bypass, then array.
    always_comb begin
        rd   = '0;
        busy = '0;
        for (int k = 0; k < 2; k++) begin
            if (zr && (ra[k] == '0)) begin
                rd[k]   = '0;
                busy[k] = 1'b0;
            end else begin
                if (bus.we1 && (bus.wa1 == ra[k])) begin
                    rd[k] = bus.wd1;
                end else if (bus.we0 && (bus.wa0 == ra[k])) begin
                    rd[k] = bus.wd0;
                end else begin
                    rd[k] = regs_q[ra[k]];
                end
                // A retiring write hides the pending bit in its own cycle.
                busy[k] = pend_q[ra[k]]
                          && !(wv0 && (bus.wa0 == ra[k]))
                          && !(wv1 && (bus.wa1 == ra[k]));
            end
        end
    end

    assign bus.rd1      = rd[0];
    assign bus.rd2      = rd[1];
    assign bus.busy1    = busy[0];
    assign bus.busy2    = busy[1];
    assign bus.pend_cnt = cnt_q;

    // Next state: port 1 applied after port 0 so it wins; issue applied after clears so set wins.
    always_comb begin
        regs_d = regs_q;
        pend_d = pend_q;
        if (wv0) begin
            regs_d[bus.wa0] = bus.wd0;
            pend_d[bus.wa0] = 1'b0;
        end
        if (wv1) begin
            regs_d[bus.wa1] = bus.wd1;
            pend_d[bus.wa1] = 1'b0;
        end
        if (iv) begin
            pend_d[bus.iss_addr] = 1'b1;
        end
    end

    // Pending count is the population of the next pending vector, so it cannot wrap.
    always_comb begin
        cnt_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cnt_d = cnt_d + CNT_W'(pend_d[i]);
        end
    end

    // State registers; reset overrides any same-cycle write or issue.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            pend_q <= '0;
            cnt_q  <= '0;
        end else begin
            regs_q <= regs_d;
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
        end
    end
endmodule
`default_nettype wire

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter DATA_W, default 32, data width of each register.
REQ-002 Parameter ADDR_W, default 5, address width; depth = 2**ADDR_W registers.
REQ-003 Parameter ZERO_REG, default 1, when 1 register 0 is hardwired to zero and cannot be marked pending.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset; one clock; reset is synchronous and active-high.
REQ-006 we0  input  1  write enable, port 0.
REQ-007 wa0  input  ADDR_W  write address, port 0.
REQ-008 wd0  input  DATA_W  write data, port 0.
REQ-009 we1  input  1  write enable, port 1 (higher priority).
REQ-010 wa1  input  ADDR_W  write address, port 1.
REQ-011 wd1  input  DATA_W  write data, port 1.
REQ-012 ra1, ra2  input  ADDR_W each  read addresses.
REQ-013 rd1, rd2  output  DATA_W each  read data, combinational, with write bypass.
REQ-014 iss_en  input  1  issue strobe: marks iss_addr as pending (result outstanding).
REQ-015 iss_addr  input  ADDR_W  destination register being issued.
REQ-016 busy1, busy2  output  1 each  pending status of ra1 / ra2, combinational.
REQ-017 pend_cnt  output  ADDR_W+1  registered count of pending registers.

Function
REQ-018 Write: at rising edge, if weN and not (ZERO_REG and waN==0), register[waN] SHALL take wdN.
REQ-019 Both ports writing the same address in one cycle: port 1 data SHALL be stored; port 0 write to that address is discarded.
REQ-020 Read: rdK SHALL equal 0 when ZERO_REG and raK==0; else wd1 if we1 and wa1==raK; else wd0 if we0 and wa0==raK; else register[raK].
REQ-021 Scoreboard: one pending bit per register, all 0 after reset.
REQ-022 Set: iss_en at rising edge SHALL set pending[iss_addr], ignored when ZERO_REG and iss_addr==0.
REQ-023 Clear: any valid write (REQ-018) SHALL clear pending[waN] at the same edge.
REQ-024 Set and clear of the same address in one cycle: set SHALL win (new producer supersedes retiring one).
REQ-025 Issue to an already-pending register: bit stays 1, pend_cnt unchanged.
REQ-026 busyK SHALL equal pending[raK] AND NOT (valid write to raK this cycle); iss_en does not affect busy combinationally.
REQ-027 busyK SHALL be 0 for raK==0 when ZERO_REG.
REQ-028 pend_cnt SHALL equal, one cycle after each edge, the population count of pending bits; updated as +1 per newly set bit, -1 per cleared bit, both write ports counted independently when addresses differ.
REQ-029 pend_cnt SHALL never wrap; maximum value is 2**ADDR_W - ZERO_REG.
REQ-030 Writes to non-pending registers SHALL store data normally with no pend_cnt change.

Reset
REQ-031 reset high at a rising edge SHALL zero all registers, all pending bits and pend_cnt, overriding any same-cycle write or issue.
REQ-032 While reset is high, rd1/rd2 bypass from write ports SHALL still follow REQ-020 combinationally; no state changes.
REQ-033 Reset asserted mid-operation with pending registers SHALL drop them all; subsequent writes to those addresses SHALL not decrement pend_cnt below 0.

Verification
REQ-034 Write we0=1, wa0=3, wd0=0x1234; next cycle ra1=3 -> rd1=0x1234; same cycle ra2=3 -> rd2=0x1234 via bypass.
REQ-035 we0=1 wa0=7 wd0=0xAAAA and we1=1 wa1=7 wd1=0x5555 same cycle -> register 7 = 0x5555 after edge.
REQ-036 we1=1 wa1=0 wd1=0xFFFF_FFFF, iss_en=1 iss_addr=0 -> rd1(ra1=0)=0, busy1=0, pend_cnt=0.
REQ-037 Issue 4, 5, 6 on consecutive cycles -> pend_cnt 1,2,3; write 5 -> pend_cnt 2, busy(ra=5) drops to 0 during write cycle.
REQ-038 iss_en iss_addr=9 with we0 wa0=9 same cycle while 9 pending -> pending[9] stays 1, pend_cnt unchanged.
REQ-039 Three registers pending, register 2 = 0x77, assert reset one cycle -> all registers 0, pend_cnt=0, busy1/busy2=0; later write to a formerly pending address leaves pend_cnt=0.
